// File: rtl/fmc_adc_acq_buffer.sv
// fmc_adc_acq_buffer: trigger-based circular capture of 4-channel ADC words
// with a pre/post-trigger window and a sequential readout port.
`default_nettype none

module fmc_adc_acq_buffer #(
  parameter int ADDR_WIDTH = 10,
  parameter int CH_WIDTH   = 17
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [CH_WIDTH-1:0]     adc0_data,
  input  logic [CH_WIDTH-1:0]     adc1_data,
  input  logic [CH_WIDTH-1:0]     adc2_data,
  input  logic [CH_WIDTH-1:0]     adc3_data,
  input  logic                    trigger,
  input  logic                    arm,
  input  logic [ADDR_WIDTH:0]     pre_samples,
  input  logic [ADDR_WIDTH:0]     post_samples,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic                    ov_seen,
  output logic [ADDR_WIDTH-1:0]   trig_addr,
  input  logic                    rd_en,
  output logic [4*CH_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_last
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int DW    = 4*CH_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] C_DEPTH = (ADDR_WIDTH+2)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_FILL, S_WAIT_TRIG, S_POST, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]  trig_addr_q, trig_addr_d;
  logic [CNT_W-1:0]       pre_q, pre_d;
  logic [CNT_W-1:0]       post_q, post_d;
  logic [CNT_W-1:0]       fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]       post_cnt_q, post_cnt_d;
  logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   ov_seen_q, ov_seen_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_last_q, rd_last_d;
  logic [DW-1:0]          rd_data_q;
  logic                   wr_en;
  logic                   rd_fire;

  logic [DW-1:0]          mem [DEPTH];

  logic [CNT_W-1:0]       post_eff;
  logic [ADDR_WIDTH+1:0]  win_sum;
  logic [CNT_W-1:0]       win_total;
  logic [DW-1:0]          wr_data;
  logic                   wr_ov;

  assign post_eff  = (post_samples == '0) ? CNT_W'(1) : post_samples;
  assign win_sum   = {1'b0, pre_samples} + {1'b0, post_eff};
  assign win_total = pre_q + post_q;
  assign wr_data   = {adc3_data, adc2_data, adc1_data, adc0_data};
  assign wr_ov     = adc0_data[CH_WIDTH-1] | adc1_data[CH_WIDTH-1] |
                     adc2_data[CH_WIDTH-1] | adc3_data[CH_WIDTH-1];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    pre_d       = pre_q;
    post_d      = post_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    cfg_err_d   = cfg_err_q;
    ov_seen_d   = ov_seen_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    wr_en       = 1'b0;
    rd_fire     = 1'b0;

    if (arm) begin
      pre_d      = pre_samples;
      post_d     = post_eff;
      ov_seen_d  = 1'b0;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      post_cnt_d = '0;
      rd_cnt_d   = '0;
      if (win_sum > C_DEPTH) begin
        cfg_err_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        cfg_err_d = 1'b0;
        state_d   = (pre_samples == '0) ? S_WAIT_TRIG : S_PRE_FILL;
      end
    end else begin
      case (state_q)
        S_PRE_FILL: begin
          if (sample_valid) begin
            wr_en      = 1'b1;
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
            if (fill_cnt_d == pre_q) state_d = S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (trigger) begin
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = post_q;
            state_d     = S_POST;
            // A valid word in the trigger cycle is itself the first post sample.
            if (sample_valid) begin
              wr_en      = 1'b1;
              post_cnt_d = post_q - CNT_W'(1);
              if (post_q == CNT_W'(1)) state_d = S_DONE;
            end
          end else if (sample_valid) begin
            wr_en = 1'b1;
          end
        end
        S_POST: begin
          if (sample_valid) begin
            wr_en      = 1'b1;
            post_cnt_d = post_cnt_q - CNT_W'(1);
            if (post_cnt_q == CNT_W'(1)) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (rd_en && (rd_cnt_q != win_total)) begin
            rd_fire    = 1'b1;
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            rd_cnt_d   = rd_cnt_q + CNT_W'(1);
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_cnt_d == win_total);
          end
        end
        default: ;
      endcase
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (wr_ov) ov_seen_d = 1'b1;
    end

    // Oldest window word sits pre entries behind the trigger sample.
    if ((state_q != S_DONE) && (state_d == S_DONE)) begin
      rd_ptr_d = trig_addr_d - pre_q[ADDR_WIDTH-1:0];
      rd_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      cfg_err_q   <= 1'b0;
      ov_seen_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      cfg_err_q   <= cfg_err_d;
      ov_seen_q   <= ov_seen_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      if (rd_fire) rd_data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign busy      = (state_q == S_PRE_FILL) || (state_q == S_WAIT_TRIG) ||
                     (state_q == S_POST);
  assign done      = (state_q == S_DONE);
  assign cfg_err   = cfg_err_q;
  assign ov_seen   = ov_seen_q;
  assign trig_addr = trig_addr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;

endmodule

`default_nettype wire
